// File: rtl/blink_stream_loader.sv
// Stream-to-operand loader for the Blink cipher core. It assembles the key, tweak and
// plaintext from 32-bit words, runs the core for CORE_LAT cycles and returns the result.
module blink_stream_loader #(
    parameter  int N        = 64,
    parameter  int ROUNDS   = 14,
    parameter  int WW       = 32,
    parameter  int CORE_LAT = 15,
    localparam int KW       = N * ROUNDS / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [WW-1:0] s_data,
    input  logic          s_first,
    input  logic          s_enc,
    input  logic          s_reuse_key,
    output logic          core_enc,
    output logic [KW-1:0] core_K0,
    output logic [N-1:0]  core_T,
    output logic [N-1:0]  core_P,
    input  logic [N-1:0]  core_C,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [N-1:0]  m_data,
    output logic          m_err
);

    localparam int KWORDS = KW / WW;
    localparam int TWORDS = N / WW;
    localparam int CNTW   = (KWORDS > 1) ? $clog2(KWORDS) : 1;
    localparam int CCW    = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_TWK,
        S_PT,
        S_RUN,
        S_OUT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_ready;
    logic [CNTW-1:0] r_wcnt;
    logic [CCW-1:0]  r_ccnt;
    logic            r_enc;
    logic            r_key_loaded;
    logic            r_m_valid;
    logic [N-1:0]    r_m_data;
    logic            r_m_err;
    logic [KW-1:0]   r_k0;
    logic [N-1:0]    r_t;
    logic [N-1:0]    r_p;

    logic            w_acc;
    logic            w_start;
    logic            w_field_done;
    logic            w_run_done;
    logic [CNTW-1:0] w_last_idx;

    // A first-flagged word restarts framing from any load state, including IDLE.
    assign w_acc        = s_valid & r_ready;
    assign w_start      = w_acc & s_first;
    assign w_last_idx   = (r_state == S_KEY) ? CNTW'(KWORDS - 1) : CNTW'(TWORDS - 1);
    assign w_field_done = w_acc & ~s_first & (r_state != S_IDLE) & (r_wcnt == w_last_idx);
    assign w_run_done   = (r_state == S_RUN) & (r_ccnt == CCW'(CORE_LAT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_KEY, S_TWK, S_PT: begin
                if (w_start) begin
                    w_next = s_reuse_key ? S_TWK : S_KEY;
                end else if (w_field_done) begin
                    case (r_state)
                        S_KEY:   w_next = S_TWK;
                        S_TWK:   w_next = S_PT;
                        default: w_next = S_RUN;
                    endcase
                end
            end
            S_RUN:   if (w_run_done) w_next = S_OUT;
            S_OUT:   if (m_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, matching the hardware it describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b0;
            r_wcnt       <= '0;
            r_ccnt       <= '0;
            r_enc        <= 1'b0;
            r_key_loaded <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            // Ready is derived from the next state so it never depends on m_ready combinationally.
            r_ready <= (w_next == S_IDLE) || (w_next == S_KEY) ||
                       (w_next == S_TWK) || (w_next == S_PT);

            if (w_start) begin
                r_enc   <= s_enc;
                r_m_err <= s_reuse_key & ~r_key_loaded;
                r_wcnt  <= CNTW'(1);
                // A new key overwrites word 0 at once, so the old key is no longer whole.
                if (!s_reuse_key) r_key_loaded <= 1'b0;
            end else if (w_field_done) begin
                r_wcnt <= '0;
                if (r_state == S_KEY) r_key_loaded <= 1'b1;
            end else if (w_acc && (r_state != S_IDLE)) begin
                r_wcnt <= CNTW'(r_wcnt + 1'b1);
            end

            if (r_state == S_RUN) begin
                r_ccnt <= w_run_done ? '0 : CCW'(r_ccnt + 1'b1);
            end

            if (w_run_done) begin
                r_m_valid <= 1'b1;
                r_m_data  <= core_C;
            end else if ((r_state == S_OUT) && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    // NOTE: the wide operand registers are reset on purpose: a reuse frame issued
    // straight after reset must drive an all-zero key into the core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k0 <= '0;
            r_t  <= '0;
            r_p  <= '0;
        end else if (w_acc) begin
            if (s_first) begin
                if (s_reuse_key) r_t[0 +: WW] <= s_data;
                else             r_k0[0 +: WW] <= s_data;
            end else begin
                case (r_state)
                    S_KEY:   r_k0[int'(r_wcnt) * WW +: WW] <= s_data;
                    S_TWK:   r_t[int'(r_wcnt) * WW +: WW]  <= s_data;
                    S_PT:    r_p[int'(r_wcnt) * WW +: WW]  <= s_data;
                    default: ;
                endcase
            end
        end
    end

    assign s_ready  = r_ready;
    assign core_enc = r_enc;
    assign core_K0  = r_k0;
    assign core_T   = r_t;
    assign core_P   = r_p;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_err    = r_m_err;

endmodule

// File: tb/tb_blink_stream_loader.sv
// Self-checking bench for blink_stream_loader: directed frames plus random frames,
// compared against a frame-level model of key state and a latency-gated core model.
module tb_blink_stream_loader;

    localparam int N        = 64;
    localparam int ROUNDS   = 14;
    localparam int WW       = 32;
    localparam int CORE_LAT = 15;
    localparam int KW       = N * ROUNDS / 2;
    localparam int KWORDS   = KW / WW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_first = 1'b0;
    logic          s_enc = 1'b0;
    logic          s_reuse_key = 1'b0;
    logic          m_ready = 1'b0;
    logic [WW-1:0] s_data = '0;
    logic          s_ready;
    logic          core_enc;
    logic [KW-1:0] core_K0;
    logic [N-1:0]  core_T;
    logic [N-1:0]  core_P;
    logic [N-1:0]  core_C;
    logic          m_valid;
    logic [N-1:0]  m_data;
    logic          m_err;

    blink_stream_loader #(.N(N), .ROUNDS(ROUNDS), .WW(WW), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_first(s_first),
        .s_enc(s_enc), .s_reuse_key(s_reuse_key),
        .core_enc(core_enc), .core_K0(core_K0), .core_T(core_T), .core_P(core_P),
        .core_C(core_C),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    // Core model: the result is only correct once the operands have been stable long enough.
    logic [KW+2*N:0] prev_ops = '0;
    int stable = 0;
    always @(negedge clk) begin
        if ({core_enc, core_K0, core_T, core_P} !== prev_ops) stable = 0;
        else if (stable < 1000) stable++;
        prev_ops = {core_enc, core_K0, core_T, core_P};
    end
    assign core_C = (stable >= CORE_LAT - 1) ? (core_P ^ core_T ^ core_K0[63:0])
                                             : ~(core_P ^ core_T ^ core_K0[63:0]);

    logic [KW-1:0] mdl_k0 = '0;
    bit            mdl_loaded = 1'b0;

    task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [WW-1:0] d, input bit first, input bit enc, input bit reuse);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_first = first; s_enc = enc; s_reuse_key = reuse;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!s_ready) check("s_ready_wait", {447'b0, s_ready}, 1);
        @(posedge clk); #1;
        s_valid = 1'b0; s_first = 1'b0;
    endtask

    task automatic gap(input int maxg);
        repeat ($urandom_range(0, maxg)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic partial_key(input int nw, input logic [KW-1:0] key);
        mdl_loaded = 1'b0;
        for (int i = 0; i < nw; i++) begin
            put(key[i*WW +: WW], i == 0, 1'b0, 1'b0);
            mdl_k0[i*WW +: WW] = key[i*WW +: WW];
        end
    endtask

    task automatic load_frame(input bit reuse, input bit enc, input logic [KW-1:0] key,
                              input logic [63:0] t, input logic [63:0] p, input int maxg,
                              output logic [63:0] exp_c, output bit exp_err);
        exp_err = reuse & !mdl_loaded;
        if (!reuse) begin
            mdl_loaded = 1'b0;
            for (int i = 0; i < KWORDS; i++) begin
                put(key[i*WW +: WW], i == 0, enc, 1'b0);
                mdl_k0[i*WW +: WW] = key[i*WW +: WW];
                gap(maxg);
            end
            mdl_loaded = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            put(t[i*WW +: WW], reuse && (i == 0), enc, reuse);
            gap(maxg);
        end
        for (int i = 0; i < 2; i++) begin
            put(p[i*WW +: WW], 1'b0, enc, reuse);
            if (i == 0) gap(maxg);
        end
        exp_c = p ^ t ^ mdl_k0[63:0];
    endtask

    task automatic finish_frame(input logic [63:0] t, input logic [63:0] p, input bit enc,
                                input bit exp_err, input logic [63:0] exp_c, input int hold);
        int t0 = cyc;
        int n = 0;
        check("s_ready_run", {447'b0, s_ready}, 0);
        check("core_T", KW'(core_T), KW'(t));
        check("core_P", KW'(core_P), KW'(p));
        check("core_K0", core_K0, mdl_k0);
        check("core_enc", {447'b0, core_enc}, KW'(enc));
        while (!m_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("m_valid_wait", {447'b0, m_valid}, 1);
        check("latency", KW'(cyc - t0), CORE_LAT);
        check("m_data", KW'(m_data), KW'(exp_c));
        check("m_err", {447'b0, m_err}, KW'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {447'b0, m_valid}, 1);
            check("hold_data", KW'(m_data), KW'(exp_c));
            check("hold_err", {447'b0, m_err}, KW'(exp_err));
            check("hold_s_ready", {447'b0, s_ready}, 0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("m_valid_drop", {447'b0, m_valid}, 0);
        check("s_ready_idle", {447'b0, s_ready}, 1);
    endtask

    task automatic do_frame(input bit reuse, input bit enc, input logic [KW-1:0] key,
                            input logic [63:0] t, input logic [63:0] p, input int maxg,
                            input int hold);
        logic [63:0] exp_c;
        bit exp_err;
        load_frame(reuse, enc, key, t, p, maxg, exp_c, exp_err);
        finish_frame(t, p, enc, exp_err, exp_c, hold);
    endtask

    initial begin
        logic [KW-1:0] key;
        logic [63:0]   exp_c;
        bit            exp_err;
        int            seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", {447'b0, s_ready}, 0);
        check("rst_m_valid", {447'b0, m_valid}, 0);
        check("rst_m_data", KW'(m_data), 0);
        check("rst_m_err", {447'b0, m_err}, 0);
        check("rst_core_K0", core_K0, 0);
        check("rst_core_TP", KW'({core_T, core_P}), 0);
        check("rst_core_enc", {447'b0, core_enc}, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("s_ready_after_rst", {447'b0, s_ready}, 1);

        // Reuse straight after reset runs on the all-zero key and flags the error.
        do_frame(1'b1, 1'b0, '0, 64'h0, 64'h5, 0, 0);
        check("reuse_rst_data", KW'(m_data), 64'h5);

        // Words without a first flag in IDLE are swallowed.
        put(32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        put(32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
        check("discard_K0", core_K0, mdl_k0);
        check("discard_T", KW'(core_T), 0);

        for (int i = 0; i < KWORDS; i++) key[i*WW +: WW] = WW'(i);
        load_frame(1'b0, 1'b1, key, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 0, exp_c, exp_err);
        check("k0_low", KW'(core_K0[63:0]), 64'h0000000100000000);
        check("enc_frame_data", KW'(exp_c),
              KW'(64'h0123456789ABCDEF ^ 64'hFEDCBA9876543210 ^ 64'h0000000100000000));
        finish_frame(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1, exp_err, exp_c, 0);

        do_frame(1'b1, 1'b0, '0, 64'h0, 64'h1, 0, 0);

        // Resync on word 9 of a key load, then a full frame of 17 more words.
        for (int i = 0; i < KWORDS; i++) key[i*WW +: WW] = $urandom;
        partial_key(9, key);
        for (int i = 0; i < KWORDS; i++) key[i*WW +: WW] = $urandom;
        do_frame(1'b0, 1'b1, key, {$urandom, $urandom}, {$urandom, $urandom}, 1, 0);
        do_frame(1'b1, 1'b1, '0, {$urandom, $urandom}, {$urandom, $urandom}, 1, 0);

        // Reuse resync inside a key load keeps the partial key and reports the error.
        for (int i = 0; i < KWORDS; i++) key[i*WW +: WW] = $urandom;
        partial_key(5, key);
        do_frame(1'b1, 1'b0, '0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0);

        // Downstream backpressure for 20 cycles.
        for (int i = 0; i < KWORDS; i++) key[i*WW +: WW] = $urandom;
        do_frame(1'b0, 1'b0, key, {$urandom, $urandom}, {$urandom, $urandom}, 0, 20);

        // Reset during RUN drops the frame.
        load_frame(1'b1, 1'b1, '0, {$urandom, $urandom}, {$urandom, $urandom}, 0, exp_c, exp_err);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_outputs", KW'({m_valid, m_err, s_ready, core_enc}), 0);
        check("midrst_m_data", KW'(m_data), 0);
        check("midrst_core_K0", core_K0, 0);
        check("midrst_core_TP", KW'({core_T, core_P}), 0);
        mdl_k0 = '0;
        mdl_loaded = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < CORE_LAT + 5; i++) begin
            @(posedge clk); #1;
            if (m_valid) seen++;
        end
        check("no_valid_after_rst", KW'(seen), 0);
        do_frame(1'b1, 1'b0, '0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0);

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < KWORDS; i++) key[i*WW +: WW] = $urandom;
            do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), key,
                     {$urandom, $urandom}, {$urandom, $urandom}, 2, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blink_stream_loader.md
# blink_stream_loader

Upstream feeder for the Blink 64-bit-block / 448-bit-round-key cipher core. Accepts a 32-bit valid/ready word stream and assembles the wide operands: key (K0, 448 bits), tweak (64) and plaintext (64). It drives those operands and the enc/dec mode into the core and holds them stable for the core's fixed latency. It then captures the 64-bit result and presents it on a valid/ready output port, with optional key reuse across frames.

## Interface
- N, 64, block width
- ROUNDS, 14, cipher rounds; key width KW = N*ROUNDS/2 = 448
- WW, 32, stream word width; KWORDS = KW/WW = 14, TWORDS = PWORDS = 2
- CORE_LAT, 15, cycles from stable core inputs to valid core_C (≥1)

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- s_valid  in  1  input word valid
- s_ready  out  1  loader accepts word this cycle
- s_data  in  32  input word
- s_first  in  1  marks first word of a frame
- s_enc  in  1  mode for frame, sampled on first word (1 = encrypt)
- s_reuse_key  in  1  sampled on first word; 1 = frame carries no key words
- core_enc  out  1  mode to core
- core_K0  out  448  round-key material to core
- core_T  out  64  tweak to core
- core_P  out  64  plaintext/ciphertext to core
- core_C  in  64  core result
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  64  captured result
- m_err  out  1  frame used reuse with no key loaded

## Operation
- Handshake: word transferred on an edge with s_valid & s_ready; result transferred with m_valid & m_ready.
- Word packing: little-endian. The k-th word of a field fills bits [32k+31:32k].
- Full frame order: 14 key words, 2 tweak words, 2 plaintext words (18). Reuse frame: 2 tweak, 2 plaintext (4).
- FSM states: IDLE, KEY, TWK, PT, RUN, OUT.
- IDLE: s_ready=1. A word with s_first=0 is accepted and discarded.
  - With s_first=1: latch s_enc into core_enc and the word into word 0 of KEY, or of TWK if s_reuse_key=1.
  - Word counter is set to 1; go to KEY or TWK.
- KEY/TWK/PT: s_ready=1. Each accepted word is written at the counter index.
  - When the last word of a field is accepted: counter → 0 and advance (KEY→TWK→PT→RUN).
  - Completing KEY sets key_loaded=1.
- Resync: in KEY/TWK/PT, a word with s_first=1 aborts the current frame.
  - The aborted frame is treated as if that word had arrived in IDLE.
  - Partially written key words remain in core_K0; key_loaded is cleared if the aborted frame was loading a key.
- Reuse check: m_err for the frame = s_reuse_key & !key_loaded, sampled on the first word.
  - That frame still runs, using the current core_K0 (all-zero after reset).
- RUN: s_ready=0; operands frozen; cycle counter counts 0..CORE_LAT-1.
  - On the edge where count = CORE_LAT-1: m_data ← core_C, m_valid ← 1, go to OUT.
- OUT: s_ready=0; m_valid, m_data and m_err held stable until m_ready.
  - On the accepting edge: m_valid ← 0, go to IDLE.
- core_K0/core_T/core_P change only on accepted words; they hold their values in all other states.

## Timing
- Reset (rst=0, async) values:
  - state IDLE, s_ready 0 while rst asserted, 1 in the first cycle after release.
  - m_valid 0, m_data 0, m_err 0, core_enc 0, core_K0/T/P 0, key_loaded 0, counters 0.
- Reset mid-frame or mid-RUN: the frame is lost and no result is issued.
- Latency: if the last plaintext word is accepted at edge t, m_valid is high after edge t+CORE_LAT.
- Throughput: full frame 18 + CORE_LAT + 1 cycles min with m_ready=1. Reuse frame 4 + CORE_LAT + 1.
- s_ready is registered-state only (no combinational path from m_ready).
- m_ready high in OUT: the next frame's first word can be accepted one cycle later (IDLE).
- s_valid=0 gaps in any load state stall the counter; no timeout.

## Test plan
- Full encrypt frame, K0 words 0x00000000..0x0000000D, T=0x0123456789ABCDEF, P=0xFEDCBA9876543210, s_enc=1, core model = P^T^K0[63:0] with CORE_LAT delay.
  -> core_K0[63:0]=0x0000000100000000. m_data=0x0123456789ABCDEF^0xFEDCBA9876543210^0x0000000100000000 exactly CORE_LAT edges after the last word. m_err=0.
- Reuse frame after the above, T=0, P=0x1, s_enc=0 -> only 4 words accepted. core_K0 unchanged, core_enc=0, m_err=0.
- Reuse frame straight after reset, P=0x5, T=0 -> core_K0=0, m_err=1, m_data=0x5 from the core model.
- s_first=1 asserted on word 9 of a key load -> frame restarts. Result appears only after 17 more words, and key_loaded is set by the new frame.
- m_ready held 0 for 20 cycles in OUT -> m_valid/m_data stable, s_ready=0 throughout. Release gives one transfer, then s_ready=1 the next cycle.
- rst pulsed low during RUN -> all outputs zero immediately. No m_valid ever for that frame. A following reuse frame flags m_err=1.
